// File: rtl/fetch_sequencer.sv
// fetch_sequencer: loads instruction memory from a word stream, then
// sequences fetch addresses with stalls, redirects and halt detection.
// Optional RUN/stall cycle counters are enabled by defining FETCH_SEQ_PERF_EN.
module fetch_sequencer #(
   parameter int          ADDR_W    = 9,
   parameter logic [31:0] HALT_WORD = 32'h0000001f
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_start,
   input  logic              load_valid,
   input  logic [31:0]       load_data,
   input  logic              load_last,
   output logic              load_ready,
   input  logic              run_start,
   input  logic              stall_req,
   input  logic              redirect_en,
   input  logic [ADDR_W-1:0] redirect_addr,
   input  logic [31:0]       fetch_instr,
   output logic [ADDR_W-1:0] addr,
   output logic              program_en,
   output logic [31:0]       program_instr,
   output logic              stall_en,
   output logic [1:0]        state,
   output logic              load_err,
   output logic [ADDR_W:0]   prog_len
`ifdef FETCH_SEQ_PERF_EN
   ,
   output logic [31:0]       run_cycles,
   output logic [31:0]       stall_cycles
`endif
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2,
      HALT = 2'd3
   } state_t;

   localparam logic [ADDR_W-1:0] A_ONE = ADDR_W'(1);
   localparam logic [ADDR_W:0]   W_ONE = (ADDR_W+1)'(1);

   state_t            st_q, st_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              pen_q, pen_d;
   logic [31:0]       pin_q, pin_d;
   logic              sen_q, sen_d;
   logic              lrdy_q, lrdy_d;
   logic              lerr_q, lerr_d;
   logic [ADDR_W:0]   plen_q, plen_d;
   logic [ADDR_W:0]   wptr_q, wptr_d;
   logic              chk_q, chk_d;

   logic              hs;
   logic              halt_hit;
   logic [ADDR_W:0]   wptr_inc;

   assign hs       = load_valid & lrdy_q;
   assign halt_hit = chk_q & (fetch_instr == HALT_WORD);
   assign wptr_inc = wptr_q + W_ONE;

   assign state         = st_q;
   assign addr          = addr_q;
   assign program_en    = pen_q;
   assign program_instr = pin_q;
   assign stall_en      = sen_q;
   assign load_ready    = lrdy_q;
   assign load_err      = lerr_q;
   assign prog_len      = plen_q;

   // State and output registers; the fetch address doubles as the PC.
   always_ff @(posedge clk) begin
      if (rst) begin
         st_q   <= IDLE;
         addr_q <= '0;
         pen_q  <= 1'b0;
         pin_q  <= '0;
         sen_q  <= 1'b1;
         lrdy_q <= 1'b0;
         lerr_q <= 1'b0;
         plen_q <= '0;
         wptr_q <= '0;
         chk_q  <= 1'b0;
      end else begin
         st_q   <= st_d;
         addr_q <= addr_d;
         pen_q  <= pen_d;
         pin_q  <= pin_d;
         sen_q  <= sen_d;
         lrdy_q <= lrdy_d;
         lerr_q <= lerr_d;
         plen_q <= plen_d;
         wptr_q <= wptr_d;
         chk_q  <= chk_d;
      end
   end

   // Next-state and next-output logic for the load/run controller.
   always_comb begin
      st_d   = st_q;
      addr_d = addr_q;
      pen_d  = 1'b0;
      pin_d  = pin_q;
      sen_d  = sen_q;
      lrdy_d = lrdy_q;
      lerr_d = lerr_q;
      plen_d = plen_q;
      wptr_d = wptr_q;
      chk_d  = 1'b0;
      unique case (st_q)
         IDLE: begin
            addr_d = '0;
            sen_d  = 1'b1;
            lrdy_d = 1'b0;
            if (load_start) begin
               st_d   = LOAD;
               wptr_d = '0;
               lrdy_d = 1'b1;
            end else if (run_start) begin
               st_d  = RUN;
               sen_d = 1'b0;
            end
         end
         LOAD: begin
            if (hs) begin
               pen_d  = 1'b1;
               addr_d = wptr_q[ADDR_W-1:0];
               pin_d  = load_data;
               wptr_d = wptr_inc;
               lrdy_d = ~wptr_inc[ADDR_W];
               if (load_last) begin
                  plen_d = wptr_inc;
                  st_d   = IDLE;
                  lrdy_d = 1'b0;
               end
            end else if (load_valid && wptr_q[ADDR_W]) begin
               lerr_d = 1'b1;
               lrdy_d = 1'b0;
               st_d   = HALT;
            end
         end
         RUN: begin
            sen_d = stall_req;
            chk_d = ~halt_hit & ~sen_q & ~redirect_en;
            if (halt_hit) begin
               st_d  = HALT;
               sen_d = 1'b1;
            end else if (redirect_en) begin
               addr_d = redirect_addr;
            end else if (!stall_req) begin
               addr_d = addr_q + A_ONE;
            end
         end
         HALT: begin
            sen_d  = 1'b1;
            lrdy_d = 1'b0;
            if (load_start) begin
               st_d   = LOAD;
               addr_d = '0;
               wptr_d = '0;
               lrdy_d = 1'b1;
               lerr_d = 1'b0;
            end else if (run_start) begin
               st_d   = RUN;
               addr_d = '0;
               sen_d  = 1'b0;
            end
         end
      endcase
   end

`ifdef FETCH_SEQ_PERF_EN
   logic run_go;

   assign run_go = (st_d == RUN) && (st_q != RUN);

   // Saturating counters of RUN cycles and stalled RUN cycles.
   always_ff @(posedge clk) begin
      if (rst || run_go) begin
         run_cycles   <= '0;
         stall_cycles <= '0;
      end else if (st_q == RUN) begin
         if (run_cycles != '1)
            run_cycles <= run_cycles + 32'd1;
         if (stall_req && (stall_cycles != '1))
            stall_cycles <= stall_cycles + 32'd1;
      end
   end
`endif

endmodule
